// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and reset vector for the instruction-fetch stage
package fetch_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = '0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular instruction buffer with single-cycle flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 31,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          valid
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign dout = mem[rd];
  assign valid = count != '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= nxt(wr);
      end
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  // the issue rule upstream must keep a push from ever landing on a full buffer
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, 1-cycle ROM issue/inflight tracking and jump redirect
module fetch_unit #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DATA_W = fetch_pkg::DATA_W,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] RV = ADDR_W'(fetch_pkg::RESET_VECTOR);
  logic inflight, pop, issue;
  logic [ADDR_W-1:0] fetch_pc, inflight_pc;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [DATA_W+ADDR_W-1:0] head;
  assign pop = instr_valid & instr_ready;
  // occupancy after this edge counts the inflight word, so it can never overflow
  assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = occ < (CW+1)'(DEPTH);
  assign rom_en = !reset & (jump | issue);
  assign rom_addr = jump ? jump_addr : fetch_pc;
  assign {instr, instr_pc} = head;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RV;
      inflight <= 1'b0;
      inflight_pc <= RV;
    end else begin
      inflight <= rom_en;
      if (rom_en) begin
        inflight_pc <= rom_addr;
        fetch_pc <= rom_addr + 1'b1;
      end
    end
  fetch_fifo #(.DEPTH(DEPTH), .W(DATA_W + ADDR_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(inflight & !jump),
    .pop(pop),
    .flush(jump),
    .din({rom_data, inflight_pc}),
    .dout(head),
    .count(count),
    .valid(instr_valid)
  );
endmodule
